// File: rtl/pwm_pkg.sv
// Shared PWM definitions: complementary-channel FSM states and default widths.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH    = 10;
  localparam int unsigned PWM_DT_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } ch_state_e;

endpackage

// File: rtl/dead_time_ch.sv
// One complementary output pair: turns the raw compare into s/nots with a
// dead-time gap at every transition; pulses shorter than the dead time are swallowed.
module dead_time_ch
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH = PWM_DT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cmp_s,
  input  logic [DT_WIDTH-1:0] dt_sh,
  output logic                s,
  output logic                nots
);

  ch_state_e           state_q, state_d;
  logic [DT_WIDTH-1:0] dtcnt_q, dtcnt_d;
  logic                cmp_q;
  logic                s_q, s_d;
  logic                nots_q, nots_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      dtcnt_q <= '0;
      cmp_q   <= 1'b0;
      s_q     <= 1'b0;
      nots_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dtcnt_q <= dtcnt_d;
      cmp_q   <= cmp_s;
      s_q     <= s_d;
      nots_q  <= nots_d;
    end
  end

  // Any compare toggle inside DEAD restarts the gap; exit side follows cmp_s at expiry.
  always_comb begin
    state_d = state_q;
    dtcnt_d = dtcnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (en) begin
          state_d = ST_DEAD;
          dtcnt_d = dt_sh;
        end
      end
      ST_DEAD: begin
        if (cmp_s != cmp_q) begin
          dtcnt_d = dt_sh;
        end else if (dtcnt_q == '0) begin
          state_d = cmp_s ? ST_HI : ST_LO;
        end else begin
          dtcnt_d = dtcnt_q - DT_WIDTH'(1);
        end
      end
      ST_HI: begin
        if (!cmp_s) begin
          state_d = ST_DEAD;
          dtcnt_d = dt_sh;
        end
      end
      ST_LO: begin
        if (cmp_s) begin
          state_d = ST_DEAD;
          dtcnt_d = dt_sh;
        end
      end
      default: state_d = ST_OFF;
    endcase
    if (!en) begin
      state_d = ST_OFF;
    end
    s_d    = (state_d == ST_HI);
    nots_d = (state_d == ST_LO);
  end

  assign s    = s_q;
  assign nots = nots_q;

endmodule

// File: rtl/pwm_deadtime_mc.sv
// Multi-channel complementary PWM: shared edge-aligned carrier, period-shadowed
// duty/dead-time registers and one dead-time channel per output pair.
module pwm_deadtime_mc
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned WIDTH    = PWM_WIDTH,
  parameter int unsigned DT_WIDTH = PWM_DT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CH*WIDTH-1:0] d,
  input  logic [DT_WIDTH-1:0]   dt,
  output logic                  period_start,
  output logic [N_CH-1:0]       s,
  output logic [N_CH-1:0]       nots
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0]            cnt_q;
  logic                        en_q;
  logic                        first_en;
  logic                        load;
  logic [N_CH-1:0][WIDTH-1:0]  duty_sh_q;
  logic [DT_WIDTH-1:0]         dt_sh_q;
  logic [DT_WIDTH-1:0]         dt_cur;
  logic                        period_start_q;

  // On the first enabled cycle the shadows are still stale, so the live inputs are used.
  assign first_en = en & ~en_q;
  assign load     = en & ((cnt_q == CNT_MAX) | ~en_q);
  assign dt_cur   = first_en ? dt : dt_sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      en_q           <= 1'b0;
      duty_sh_q      <= '0;
      dt_sh_q        <= '0;
      period_start_q <= 1'b0;
    end else begin
      en_q           <= en;
      cnt_q          <= en ? cnt_q + WIDTH'(1) : '0;
      period_start_q <= en & (cnt_q == '0);
      if (load) begin
        duty_sh_q <= d;
        dt_sh_q   <= dt;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [WIDTH-1:0] duty_cur;
    logic             cmp;

    assign duty_cur = first_en ? d[k*WIDTH +: WIDTH] : duty_sh_q[k];
    assign cmp      = (cnt_q < duty_cur);

    dead_time_ch #(
      .DT_WIDTH (DT_WIDTH)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .cmp_s (cmp),
      .dt_sh (dt_cur),
      .s     (s[k]),
      .nots  (nots[k])
    );
  end

  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_deadtime_mc.sv
// Bench for pwm_deadtime_mc: run-length reference model checked every cycle,
// plus hand-computed per-period on-time counts.
module tb_pwm_deadtime_mc;

  localparam int unsigned N_CH     = 3;
  localparam int unsigned WIDTH    = 10;
  localparam int unsigned DT_WIDTH = 6;
  localparam int          PERIOD   = 1024;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en  = 1'b0;
  logic [N_CH*WIDTH-1:0] d   = '0;
  logic [DT_WIDTH-1:0]   dt  = '0;
  logic                  period_start;
  logic [N_CH-1:0]       s;
  logic [N_CH-1:0]       nots;

  int total = 0;
  int bad   = 0;

  // Model: an output side is on when the last dt+2 compare samples in this
  // enabled run all agree on that side.
  int              mcnt = 0;
  bit              men_prev = 1'b0;
  int              mdsh [N_CH];
  int              mdtsh = 0;
  int              run_len [N_CH];
  bit              run_val [N_CH];
  logic [N_CH-1:0] exp_s = '0;
  logic [N_CH-1:0] exp_n = '0;
  logic            exp_ps = 1'b0;

  int cs [N_CH];
  int cn [N_CH];

  always #5 clk = ~clk;

  pwm_deadtime_mc #(
    .N_CH     (N_CH),
    .WIDTH    (WIDTH),
    .DT_WIDTH (DT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .d            (d),
    .dt           (dt),
    .period_start (period_start),
    .s            (s),
    .nots         (nots)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : model
    bit first;
    int dtx;
    int dcur;
    bit sv;
    for (int k = 0; k < N_CH; k++) begin
      mdsh[k] = 0; run_len[k] = 0; run_val[k] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mcnt = 0; men_prev = 1'b0; mdtsh = 0;
        for (int k = 0; k < N_CH; k++) begin
          mdsh[k] = 0; run_len[k] = 0; run_val[k] = 1'b0;
        end
        exp_s = '0; exp_n = '0; exp_ps = 1'b0;
      end else begin
        first = en && !men_prev;
        dtx   = first ? int'(dt) : mdtsh;
        for (int k = 0; k < N_CH; k++) begin
          dcur = first ? int'(d[k*WIDTH +: WIDTH]) : mdsh[k];
          sv   = (mcnt < dcur);
          if (!en) run_len[k] = 0;
          else if (run_len[k] > 0 && run_val[k] == sv) run_len[k]++;
          else begin run_val[k] = sv; run_len[k] = 1; end
          exp_s[k] = en && run_val[k]  && (run_len[k] >= dtx + 2);
          exp_n[k] = en && !run_val[k] && (run_len[k] >= dtx + 2);
        end
        exp_ps = en && (mcnt == 0);
        if (en && (mcnt == PERIOD - 1 || !men_prev)) begin
          for (int k = 0; k < N_CH; k++) mdsh[k] = int'(d[k*WIDTH +: WIDTH]);
          mdtsh = int'(dt);
        end
        mcnt     = en ? (mcnt + 1) % PERIOD : 0;
        men_prev = en;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("s", int'(s), int'(exp_s));
      chk("nots", int'(nots), int'(exp_n));
      chk("period_start", int'(period_start), int'(exp_ps));
      chk("overlap", int'(s & nots), 0);
    end
  end

  task automatic set_duty(input int k, input int v);
    d[k*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 2 * PERIOD + 8);
    if (!period_start) begin
      total++; bad++;
      $display("FAIL ps_wait no period_start within %0d cycles", n);
    end
  endtask

  // Counts on-cycles of each side over one full period starting at period_start.
  task automatic measure();
    for (int k = 0; k < N_CH; k++) begin cs[k] = 0; cn[k] = 0; end
    wait_ps();
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      for (int k = 0; k < N_CH; k++) begin
        cs[k] += int'(s[k]);
        cn[k] += int'(nots[k]);
      end
    end
  endtask

  function automatic int pick_duty();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return PERIOD - 1;
      2:       return int'($urandom_range(0, 20));
      3:       return int'($urandom_range(PERIOD - 21, PERIOD - 1));
      default: return int'($urandom_range(0, PERIOD - 1));
    endcase
  endfunction

  initial begin : stim
    int quiet;
    int hold;
    repeat (3) @(negedge clk);
    chk("rst_s", int'(s), 0);
    chk("rst_nots", int'(nots), 0);
    chk("rst_ps", int'(period_start), 0);
    rst = 1'b0;

    // Disabled: everything stays quiet for two periods.
    quiet = 0;
    repeat (2 * PERIOD) begin
      @(negedge clk);
      if (s != '0 || nots != '0 || period_start) quiet++;
    end
    chk("idle_quiet", quiet, 0);

    // Three channels, dt=4.
    set_duty(0, 256); set_duty(1, 512); set_duty(2, 768);
    dt = DT_WIDTH'(4);
    en = 1'b1;
    measure();
    measure();
    chk("t2_s0", cs[0], 251);   chk("t2_n0", cn[0], 763);
    chk("t2_s1", cs[1], 507);   chk("t2_n1", cn[1], 507);
    chk("t2_s2", cs[2], 763);   chk("t2_n2", cn[2], 251);

    // Mid-period duty change only takes effect after the wrap.
    wait_ps();
    repeat (99) @(negedge clk);
    set_duty(0, 512);
    measure();
    chk("t3_s0", cs[0], 507);
    chk("t3_n0", cn[0], 507);

    // Pulse shorter than the dead time is swallowed.
    en = 1'b0;
    repeat (5) @(negedge clk);
    dt = DT_WIDTH'(10);
    set_duty(0, 5);
    en = 1'b1;
    measure();
    measure();
    chk("t4_s0", cs[0], 0);
    chk("t4_n0", cn[0], PERIOD - 16);

    // Zero duty, zero dead time: one DEAD cycle then low side forever.
    en = 1'b0;
    repeat (5) @(negedge clk);
    d  = '0;
    dt = '0;
    en = 1'b1;
    @(negedge clk);
    chk("t5_dead", int'({s, nots}), 0);
    @(negedge clk);
    chk("t5_lo", int'(nots), 7);
    measure();
    chk("t5_n_all", cn[0] + cn[1] + cn[2], 3 * PERIOD);
    chk("t5_s_all", cs[0] + cs[1] + cs[2], 0);

    // Asynchronous reset in the middle of a high pulse.
    en = 1'b0;
    repeat (5) @(negedge clk);
    set_duty(0, 256); set_duty(1, 512); set_duty(2, 768);
    dt = DT_WIDTH'(4);
    en = 1'b1;
    measure();
    wait_ps();
    repeat (299) @(negedge clk);
    chk("t6_s1_hi", int'(s[1]), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_s", int'(s), 0);
    chk("t6_async_nots", int'(nots), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_restart_ps", int'(period_start), 1);

    // Randomised sessions: dt set while idle, duties changed at random times.
    for (int sess = 0; sess < 25; sess++) begin
      en = 1'b0;
      repeat ($urandom_range(1, 20)) @(negedge clk);
      dt = ($urandom_range(0, 3) == 0) ? '0 : DT_WIDTH'($urandom_range(0, 63));
      for (int k = 0; k < N_CH; k++) set_duty(k, pick_duty());
      en = 1'b1;
      hold = int'($urandom_range(200, 1500));
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 63) == 0) set_duty(int'($urandom_range(0, N_CH - 1)), pick_duty());
      end
    end
    en = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
